// File: rtl/ext_ram_banked_pkg.sv
// Shared types and geometry helpers for the LDPC message-store RAM: FSM state
// encoding and bank-count / bank-depth derivation. Pure definitions, no timing or flow control.
package ldpc_mem_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic int bank_bits(input int num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int bank_depth(input int ram_depth, input int num_banks);
    return ram_depth / num_banks;
  endfunction

endpackage

// File: rtl/ext_ram_banked_mem_bank.sv
// One interleaved bank: simple dual-port, synchronous write, registered read (1 cycle).
// No flow control; the read register holds its value while re is low.
module mem_bank
  import ldpc_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_AW     = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ROW_AW-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ROW_AW-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Only the read register is reset so rd_data comes out of reset as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ext_ram_banked.sv
// Banked 1W/1R message RAM with clear engine; reads return after 1 cycle, write-first on collision.
// No backpressure: accesses arriving while the clear engine is busy are dropped and flagged on access_err.
module ext_ram_banked
  import ldpc_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_BANKS  = 4,
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  chip_sel,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  clear_start,
  output logic                  busy,
  output logic                  access_err
);

  localparam int BANK_BITS  = bank_bits(NUM_BANKS);
  localparam int BANK_DEPTH = bank_depth(RAM_DEPTH, NUM_BANKS);
  localparam int SEL_W      = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ROW_W      = ADDR_WIDTH - BANK_BITS;
  localparam int ROW_AW     = (ROW_W > 0) ? ROW_W : 1;

  state_e                state_d, state_q;
  logic [ROW_AW-1:0]     clr_row_d, clr_row_q;
  logic                  rd_valid_d, rd_valid_q;
  logic                  access_err_d, access_err_q;
  logic [SEL_W-1:0]      rd_sel_d, rd_sel_q;
  logic                  fwd_d, fwd_q;
  logic [DATA_WIDTH-1:0] fwd_data_d, fwd_data_q;

  logic                  wr_ok, rd_ok;
  logic [SEL_W-1:0]      wr_bank, rd_bank;
  logic [ROW_AW-1:0]     wr_row, rd_row;
  logic [NUM_BANKS-1:0]  bank_we, bank_re;
  logic [ROW_AW-1:0]     bank_waddr;
  logic [DATA_WIDTH-1:0] bank_wdata;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

  assign busy  = (state_q == ST_CLEAR);
  assign wr_ok = chip_sel && wr_en && !busy;
  assign rd_ok = chip_sel && rd_en && !busy;

  // Low address bits pick the bank so sequential addresses spread across banks.
  assign wr_bank = SEL_W'(wr_addr & ADDR_WIDTH'(NUM_BANKS - 1));
  assign rd_bank = SEL_W'(rd_addr & ADDR_WIDTH'(NUM_BANKS - 1));
  assign wr_row  = ROW_AW'(wr_addr >> BANK_BITS);
  assign rd_row  = ROW_AW'(rd_addr >> BANK_BITS);

  always_comb begin
    state_d   = state_q;
    clr_row_d = clr_row_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_row_q == ROW_AW'(BANK_DEPTH - 1)) begin
          state_d   = ST_IDLE;
          clr_row_d = '0;
        end else begin
          clr_row_d = clr_row_q + ROW_AW'(1);
        end
      end
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    rd_valid_d   = rd_ok;
    access_err_d = chip_sel && (wr_en || rd_en) && busy;
    rd_sel_d     = rd_sel_q;
    fwd_d        = fwd_q;
    fwd_data_d   = fwd_data_q;
    if (rd_ok) begin
      rd_sel_d   = rd_bank;
      fwd_d      = wr_ok && (wr_addr == rd_addr);
      fwd_data_d = wr_data;
    end
  end

  // The clear engine owns every bank's write port while busy.
  always_comb begin
    bank_waddr = busy ? clr_row_q : wr_row;
    bank_wdata = busy ? '0 : wr_data;
    bank_we    = '0;
    bank_re    = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_we[b] = busy || (wr_ok && (wr_bank == SEL_W'(b)));
      bank_re[b] = rd_ok && (rd_bank == SEL_W'(b));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      clr_row_q    <= '0;
      rd_valid_q   <= 1'b0;
      access_err_q <= 1'b0;
      rd_sel_q     <= '0;
      fwd_q        <= 1'b0;
      fwd_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      clr_row_q    <= clr_row_d;
      rd_valid_q   <= rd_valid_d;
      access_err_q <= access_err_d;
      rd_sel_q     <= rd_sel_d;
      fwd_q        <= fwd_d;
      fwd_data_q   <= fwd_data_d;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    mem_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .ROW_AW    (ROW_AW),
      .DEPTH     (BANK_DEPTH)
    ) u_bank (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (bank_we[g]),
      .waddr(bank_waddr),
      .wdata(bank_wdata),
      .re   (bank_re[g]),
      .raddr(rd_row),
      .rdata(bank_rdata[g])
    );
  end

  assign rd_data    = fwd_q ? fwd_data_q : bank_rdata[rd_sel_q];
  assign rd_valid   = rd_valid_q;
  assign access_err = access_err_q;

endmodule

// File: tb/tb_ext_ram_banked.sv
// Scoreboard bench for ext_ram_banked: stimulus queues expected reads, a monitor checks
// data and arrival cycle whenever rd_valid is seen.
module tb_ext_ram_banked;

  logic       clk;
  logic       rst_n;
  logic       chip_sel;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       clear_start;
  logic       busy;
  logic       access_err;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  ext_ram_banked #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8),
    .NUM_BANKS (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .chip_sel   (chip_sel),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .clear_start(clear_start),
    .busy       (busy),
    .access_err (access_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: the read is sampled at the next posedge, so rd_valid
  // must be seen right after that edge, i.e. when cyc has advanced by one.
  task automatic expect_rd(input logic [7:0] data);
    exp_t e;
    e.data = data;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic cs, input logic we, input logic [7:0] wa, input logic [7:0] wd,
                       input logic re, input logic [7:0] ra, input logic cl);
    chip_sel    = cs;
    wr_en       = we;
    wr_addr     = wa;
    wr_data     = wd;
    rd_en       = re;
    rd_addr     = ra;
    clear_start = cl;
    @(negedge clk);
    chip_sel    = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    clear_start = 1'b0;
  endtask

  task automatic wait_busy_low(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Monitor: every rd_valid must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected: got rd_valid=1 data=%0h want no read (t=%0t)", rd_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(e.data));
          check("rd_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    int n;
    chip_sel = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    rd_en = 0; rd_addr = 0; clear_start = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_access_err", 32'(access_err), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    wait_busy_low(n);
    check("init_busy_cycles", 32'(n), 32'd64);

    for (int a = 0; a < 256; a++) begin
      expect_rd(8'h00);
      drive(1, 0, 0, 0, 1, 8'(a), 0);
    end

    drive(1, 1, 8'd0, 8'd75, 0, 0, 0);
    drive(1, 1, 8'd1, 8'd13, 0, 0, 0);
    expect_rd(8'd75);
    drive(1, 0, 0, 0, 1, 8'd0, 0);
    expect_rd(8'd13);
    drive(1, 0, 0, 0, 1, 8'd1, 0);

    expect_rd(8'd24);
    drive(1, 1, 8'd0, 8'd24, 1, 8'd0, 0);

    drive(0, 1, 8'd3, 8'h55, 0, 0, 0);
    expect_rd(8'h00);
    drive(1, 0, 0, 0, 1, 8'd3, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 8'(4 + i), 8'(8'h11 * (i + 1)), 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      expect_rd(8'(8'h11 * (i + 1)));
      drive(1, 0, 0, 0, 1, 8'(4 + i), 0);
    end

    // Clear with a same-edge read that is still serviced, then a dropped read.
    drive(1, 1, 8'd5, 8'hAA, 0, 0, 0);
    expect_rd(8'hAA);
    drive(1, 0, 0, 0, 1, 8'd5, 1);
    check("clr_busy_rise", 32'(busy), 32'h1);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 8'd5, 0);
    check("clr_access_err_hi", 32'(access_err), 32'h1);
    check("clr_rd_valid_lo", 32'(rd_valid), 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("clr_access_err_lo", 32'(access_err), 32'h0);
    wait_busy_low(n);
    // Three of the 64 clear edges were already consumed above.
    check("clr_busy_cycles", 32'(n), 32'd61);
    expect_rd(8'h00);
    drive(1, 0, 0, 0, 1, 8'd5, 0);
    expect_rd(8'h00);
    drive(1, 0, 0, 0, 1, 8'd4, 0);

    drive(1, 1, 8'd9, 8'h99, 0, 0, 0);
    expect_rd(8'h99);
    drive(1, 0, 0, 0, 1, 8'd9, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_rd_data", 32'(rd_data), 32'h0);
    check("midrst_rd_valid", 32'(rd_valid), 32'h0);
    check("midrst_busy", 32'(busy), 32'h1);
    check("midrst_access_err", 32'(access_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_busy_low(n);
    check("midrst_busy_cycles", 32'(n), 32'd64);
    expect_rd(8'h00);
    drive(1, 0, 0, 0, 1, 8'd9, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
